// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - execute stage: single-cycle ALU plus multi-cycle shift-add multiplier
module exe_stage_mc #(
  parameter int ARQ    = 16,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ARQ-1:0]    src1,
  input  logic [ARQ-1:0]    src2,
  input  logic [ARQ-1:0]    src3,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ARQ-1:0]    alu_result,
  output logic [ARQ-1:0]    src1_out,
  output logic [ARQ-1:0]    src3_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy
);

  localparam int SHW = $clog2(ARQ);
  localparam int CW  = SHW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [ARQ-1:0]    mcand, mplier, acc, partial;
  logic [ARQ-1:0]    lat_src1, lat_src3;
  logic [CTRL_W-1:0] lat_ctrl;
  logic [ARQ-1:0]    alu_res;
  logic              alu_c;
  logic              accept, load_alu, start_mul, mul_done;

  assign in_ready  = !rst && (state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign load_alu  = accept && (op != OP_MUL);
  assign start_mul = accept && (op == OP_MUL);
  assign mul_done  = (state == S_MUL) && (cnt == CW'(1)) && !flush;
  assign busy      = (state == S_MUL);
  assign partial   = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, src1} + {1'b0, src2};
      OP_SUB:  {alu_c, alu_res} = {1'b0, src1} - {1'b0, src2};
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SHL:  alu_res = src1 << src2[SHW-1:0];
      OP_SHR:  alu_res = src1 >> src2[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_mul) state_next = S_MUL;
      S_MUL:   if (cnt == CW'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Multiplier: the multiplicand shifts left and the multiplier right, one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      lat_src1 <= '0;
      lat_src3 <= '0;
      lat_ctrl <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start_mul) begin
      cnt      <= CW'(ARQ);
      mcand    <= src1;
      mplier   <= src2;
      acc      <= '0;
      lat_src1 <= src1;
      lat_src3 <= src3;
      lat_ctrl <= ctrl_in;
    end else if (state == S_MUL) begin
      cnt    <= cnt - CW'(1);
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Output register: data only changes on a load, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      src1_out   <= '0;
      src3_out   <= '0;
      ctrl_out   <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_alu) begin
      out_valid  <= 1'b1;
      alu_result <= alu_res;
      src1_out   <= src1;
      src3_out   <= src3;
      ctrl_out   <= ctrl_in;
      flag_z     <= (alu_res == '0);
      flag_c     <= alu_c;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      alu_result <= partial;
      src1_out   <= lat_src1;
      src3_out   <= lat_src3;
      ctrl_out   <= lat_ctrl;
      flag_z     <= (partial == '0);
      flag_c     <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - directed self-checking bench for exe_stage_mc
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] src1, src2, src3, alu_result, src1_out, src3_out;
  logic [3:0]  ctrl_in, ctrl_out;
  logic        flag_z, flag_c, busy;

  int checks = 0;
  int errors = 0;

  exe_stage_mc #(.ARQ(16), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .src3(src3), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .src1_out(src1_out), .src3_out(src3_out), .ctrl_out(ctrl_out),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [3:0] k);
    op = o; src1 = a; src2 = b; src3 = c; ctrl_in = k;
  endtask

  logic [2:0]  v_op  [8];
  logic [15:0] v_a   [8];
  logic [15:0] v_b   [8];
  logic [15:0] v_res [8];
  logic        v_c   [8];

  initial begin
    int bad;
    v_op[0] = 3'd0; v_a[0] = 16'd10;    v_b[0] = 16'd20;    v_res[0] = 16'd30;    v_c[0] = 1'b0;
    v_op[1] = 3'd6; v_a[1] = 16'h0080;  v_b[1] = 16'h0013;  v_res[1] = 16'h0010;  v_c[1] = 1'b0;
    v_op[2] = 3'd0; v_a[2] = 16'h8000;  v_b[2] = 16'h8000;  v_res[2] = 16'h0000;  v_c[2] = 1'b1;
    v_op[3] = 3'd1; v_a[3] = 16'd9;     v_b[3] = 16'd5;     v_res[3] = 16'd4;     v_c[3] = 1'b0;
    v_op[4] = 3'd2; v_a[4] = 16'hF0F0;  v_b[4] = 16'hFF00;  v_res[4] = 16'hF000;  v_c[4] = 1'b0;
    v_op[5] = 3'd3; v_a[5] = 16'h00F0;  v_b[5] = 16'h0F00;  v_res[5] = 16'h0FF0;  v_c[5] = 1'b0;
    v_op[6] = 3'd4; v_a[6] = 16'hFFFF;  v_b[6] = 16'hFFFF;  v_res[6] = 16'h0000;  v_c[6] = 1'b0;
    v_op[7] = 3'd5; v_a[7] = 16'h0001;  v_b[7] = 16'h0024;  v_res[7] = 16'h0010;  v_c[7] = 1'b0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", alu_result, 0);
    check("rst_flags", {flag_z, flag_c}, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // ADD overflow wraps to zero with carry
    drive(3'd0, 16'hFFFF, 16'h0001, 16'h00AA, 4'hA);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_result", alu_result, 16'h0000);
    check("add_z", flag_z, 1);
    check("add_c", flag_c, 1);
    check("add_ctrl", ctrl_out, 4'hA);
    step();
    check("add_drain", out_valid, 0);

    // MUL 300*7
    drive(3'd7, 16'd300, 16'd7, 16'h1234, 4'h5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drive(3'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (!busy || in_ready || out_valid) bad++;
      step();
    end
    check("mul_busy_window", bad, 0);
    check("mul_last_busy", busy, 1);
    check("mul_last_not_valid", out_valid, 0);
    step();
    check("mul_valid", out_valid, 1);
    check("mul_result", alu_result, 16'h0834);
    check("mul_ctrl", ctrl_out, 4'h5);
    check("mul_src3", src3_out, 16'h1234);
    check("mul_src1", src1_out, 16'd300);
    check("mul_flag_c", flag_c, 0);
    check("mul_busy_done", busy, 0);
    step();
    check("mul_drain", out_valid, 0);

    // SUB 5-9 under backpressure, with a competing op held at the input
    out_ready = 1'b0;
    drive(3'd1, 16'd5, 16'd9, 16'd0, 4'h3);
    in_valid = 1'b1;
    step();
    drive(3'd0, 16'd1, 16'd1, 16'd0, 4'h9);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", alu_result, 16'hFFFC);
      check("stall_c", flag_c, 1);
      check("stall_ctrl", ctrl_out, 4'h3);
      check("stall_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("refill_in_ready", in_ready, 1);
    step();
    check("refill_valid", out_valid, 1);
    check("refill_result", alu_result, 16'd2);
    check("refill_ctrl", ctrl_out, 4'h9);

    // back-to-back ops, one result per cycle
    for (int k = 0; k < 8; k++) begin
      drive(v_op[k], v_a[k], v_b[k], 16'd0, 4'(k));
      #1;
      check("b2b_in_ready", in_ready, 1);
      step();
      check("b2b_valid", out_valid, 1);
      check("b2b_result", alu_result, v_res[k]);
      check("b2b_c", flag_c, v_c[k]);
      check("b2b_z", flag_z, v_res[k] == 16'd0);
      check("b2b_ctrl", ctrl_out, 32'(k));
    end
    in_valid = 1'b0;
    step();
    check("b2b_drain", out_valid, 0);

    // flush five cycles into a MUL; concurrent in_valid is dropped
    drive(3'd7, 16'd3, 16'd3, 16'd0, 4'h1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    flush = 1'b1;
    drive(3'd0, 16'd7, 16'd7, 16'd0, 4'h2);
    in_valid = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_busy", busy, 0);
    check("flush_ready_next", in_ready, 1);
    check("flush_no_valid", out_valid, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) bad++;
      step();
    end
    check("flush_mul_never_valid", bad, 0);

    // reset in the middle of a MUL, then a normal ADD
    drive(3'd7, 16'd5, 16'd5, 16'h7777, 4'hF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_result", alu_result, 0);
    check("mrst_src1", src1_out, 0);
    check("mrst_src3", src3_out, 0);
    check("mrst_ctrl", ctrl_out, 0);
    check("mrst_flags", {flag_z, flag_c}, 0);
    check("mrst_in_ready", in_ready, 1);
    drive(3'd0, 16'd2, 16'd2, 16'd0, 4'h6);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mrst_add_valid", out_valid, 1);
    check("mrst_add_result", alu_result, 16'd4);
    step();
    check("mrst_add_drain", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
